softmax_stream_lut: RTL and testbench

Streaming, parametrised softmax unit for the classifier output stage. It accepts one frame of N_CLASSES signed fixed-point logits, one per beat, and subtracts the frame maximum for numerical stability. It then evaluates exp through an internal elaboration-time LUT, accumulates the sum, forms 1/sum with a sequential restoring divider, and streams out N_CLASSES probabilities. It generalises the fixed 1024-entry, integer-step exp table: the LUT resolution is configurable, and out-of-range indices saturate instead of wrapping or overflowing.

---
 rtl/softmax_stream_lut.sv | 193 +++++++++++++++++++
 tb/tb_softmax_stream_lut.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_stream_lut.sv
// softmax_stream_lut: streaming softmax over one frame of N_CLASSES logits.
//   LOAD: buffer logits and track the running maximum.
//   EXP : e_i = LUT[min((max - x_i) >> (FRAC_W-LUT_FRAC_W), depth-1)], sum += e_i.
//   DIV : restoring divide, recip = floor(2^(2*FRAC_W) / sum).
//   OUT : stream (e_i * recip) >> FRAC_W in input order.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     logit handshake (ready only in LOAD)
//   in_data               signed logit, FRAC_W fractional bits
//   out_valid/out_ready   probability handshake, data held until accepted
//   out_data              unsigned probability, FRAC_W fractional bits
//   out_last              marks the final beat of a frame
module softmax_stream_lut #(
  parameter int unsigned N_CLASSES  = 5,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_W     = 10,
  parameter int unsigned LUT_ADDR_W = 10,
  parameter int unsigned LUT_FRAC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned LUT_DEPTH = 2 ** LUT_ADDR_W;
  localparam int unsigned E_W       = FRAC_W + 1;
  localparam int unsigned SUM_W     = FRAC_W + 1 + $clog2(N_CLASSES);
  localparam int unsigned CNT_W     = $clog2(N_CLASSES + 1);
  localparam int unsigned BIT_W     = $clog2(FRAC_W + 1);
  localparam int unsigned SHIFT     = FRAC_W - LUT_FRAC_W;

  // round(2^FRAC_W / e^x) with e^x from a positive-term Taylor series,
  // which stays accurate across the whole index range.
  function automatic int exp_lut_entry(input int unsigned k);
    real x, term, acc;
    x    = real'(k) / real'(2 ** LUT_FRAC_W);
    term = 1.0;
    acc  = 1.0;
    for (int unsigned n = 1; n < 80; n++) begin
      term = term * x / real'(n);
      acc  = acc + term;
    end
    return $rtoi(real'(2 ** FRAC_W) / acc + 0.5);
  endfunction

  logic [E_W-1:0] lut_rom [LUT_DEPTH];
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
    localparam int ENTRY = exp_lut_entry(g);
    assign lut_rom[g] = E_W'(ENTRY);
  end

  typedef enum logic [1:0] {S_LOAD, S_EXP, S_DIV, S_OUT} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic signed [DATA_W-1:0]  logit_q [N_CLASSES];
  logic signed [DATA_W-1:0]  logit_d [N_CLASSES];
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic [E_W-1:0]            e_q [N_CLASSES];
  logic [E_W-1:0]            e_d [N_CLASSES];
  logic [E_W-1:0]            lut_q, lut_d;
  logic [SUM_W-1:0]          sum_q, sum_d;
  logic [SUM_W-1:0]          rem_q, rem_d;
  logic [E_W-1:0]            recip_q, recip_d;

  logic [CNT_W-1:0]          rd_idx;
  logic signed [DATA_W-1:0]  x_sel;
  logic [DATA_W:0]           diff;
  logic [DATA_W:0]           k_full;
  logic [LUT_ADDR_W-1:0]     lut_idx;
  logic [SUM_W:0]            trial;
  logic                      div_ge;
  logic [2*E_W-1:0]          prod;

  // cnt runs to N_CLASSES in EXP (drain cycle); keep buffer reads in range.
  assign rd_idx = (cnt_q < CNT_W'(N_CLASSES)) ? cnt_q : '0;
  assign x_sel  = logit_q[rd_idx];
  assign diff   = {max_q[DATA_W-1], max_q} - {x_sel[DATA_W-1], x_sel};
  assign k_full = diff >> SHIFT;
  assign lut_idx = (k_full > (DATA_W+1)'(LUT_DEPTH - 1)) ? '1 : k_full[LUT_ADDR_W-1:0];

  assign trial  = {rem_q, 1'b0};
  assign div_ge = trial >= {1'b0, sum_q};

  assign prod = {{E_W{1'b0}}, e_q[rd_idx]} * {{E_W{1'b0}}, recip_q};

  assign in_ready  = rst_n && (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign out_last  = out_valid && (cnt_q == CNT_W'(N_CLASSES - 1));
  assign out_data  = out_valid ? DATA_W'(prod >> FRAC_W) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    logit_d   = logit_q;
    max_d     = max_q;
    e_d       = e_q;
    lut_d     = lut_q;
    sum_d     = sum_q;
    rem_d     = rem_q;
    recip_d   = recip_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          logit_d[cnt_q] = $signed(in_data);
          if (cnt_q == '0 || $signed(in_data) > max_q) max_d = $signed(in_data);
          if (cnt_q == CNT_W'(N_CLASSES - 1)) begin
            state_d = S_EXP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_EXP: begin
        // LUT read is registered: entry fetched at cnt is stored at cnt+1.
        if (cnt_q < CNT_W'(N_CLASSES)) lut_d = lut_rom[lut_idx];
        if (cnt_q != '0) begin
          e_d[cnt_q - CNT_W'(1)] = lut_q;
          sum_d = sum_q + SUM_W'(lut_q);
        end
        if (cnt_q == CNT_W'(N_CLASSES)) begin
          state_d   = S_DIV;
          cnt_d     = '0;
          bit_cnt_d = '0;
          // Dividend bits above FRAC_W yield zero quotient bits since
          // sum >= 2^FRAC_W, so start with those bits already shifted in.
          rem_d     = SUM_W'(1) << (FRAC_W - 1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        rem_d   = div_ge ? SUM_W'(trial - {1'b0, sum_q}) : trial[SUM_W-1:0];
        recip_d = {recip_q[E_W-2:0], div_ge};
        if (bit_cnt_q == BIT_W'(FRAC_W)) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (cnt_q == CNT_W'(N_CLASSES - 1)) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            max_d   = '0;
            sum_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      logit_q   <= '{default: '0};
      max_q     <= '0;
      e_q       <= '{default: '0};
      lut_q     <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      recip_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      logit_q   <= logit_d;
      max_q     <= max_d;
      e_q       <= e_d;
      lut_q     <= lut_d;
      sum_q     <= sum_d;
      rem_q     <= rem_d;
      recip_q   <= recip_d;
    end
  end

endmodule

// File: tb/tb_softmax_stream_lut.sv
// Self-checking bench for softmax_stream_lut: a floating-point reference
// model fills a scoreboard as each frame is driven; output beats are popped
// and compared as the DUT produces them.
module tb_softmax_stream_lut;

  localparam int N   = 5;
  localparam int FW  = 10;
  localparam int LAT = N + FW + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;

  softmax_stream_lut #(
    .N_CLASSES  (N),
    .DATA_W     (16),
    .FRAC_W     (FW),
    .LUT_ADDR_W (10),
    .LUT_FRAC_W (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [15:0] frame_t [N];
  typedef struct { logic [15:0] data; logic last; } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int last_acc = 0;

  task automatic check(input string tag, input int got, input int expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic push_model(input frame_t f);
    int x[N];
    int e[N];
    int mx, sum, recip;
    for (int i = 0; i < N; i++) x[i] = int'($signed(f[i]));
    mx = x[0];
    for (int i = 1; i < N; i++) if (x[i] > mx) mx = x[i];
    sum = 0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (mx - x[i]) / 16;
      if (k > 1023) k = 1023;
      e[i] = $rtoi(1024.0 * $exp(-real'(k) / 64.0) + 0.5);
      sum += e[i];
    end
    recip = (1 << 20) / sum;
    for (int i = 0; i < N; i++)
      sb.push_back('{data: 16'((e[i] * recip) >> 10), last: (i == N - 1)});
  endtask

  task automatic send_frame(input frame_t f, input int gap);
    for (int i = 0; i < N; i++) begin
      int guard;
      guard = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = f[i];
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      last_acc = cyc;
    end
  endtask

  task automatic recv_frame(input int stall_at);
    exp_t ev;
    for (int i = 0; i < N; i++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", 0, 1);
        sb.delete();
        return;
      end
      if (i == 0) check("latency", cyc - last_acc, LAT);
      if (sb.size() == 0) begin
        check("sb_underflow", 0, 1);
        return;
      end
      ev = sb[0];
      if (i == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, ev.data);
          check("hold_last", out_last, ev.last);
        end
        out_ready = 1'b1;
      end
      ev = sb.pop_front();
      check($sformatf("data[%0d]", i), out_data, ev.data);
      check($sformatf("last[%0d]", i), out_last, ev.last);
      @(posedge clk);
    end
    @(negedge clk);
    check("idle_valid", out_valid, 0);
    check("idle_ready", in_ready, 1);
  endtask

  task automatic run_frame(input frame_t f, input int gap, input int stall_at);
    push_model(f);
    send_frame(f, gap);
    recv_frame(stall_at);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    frame_t f;
    int seen;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    f = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_frame(f, 0, -1);
    f = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000, 16'h1400};
    run_frame(f, 0, -1);
    f = '{16'h2C00, 16'h3000, 16'h3400, 16'h3800, 16'h3C00};
    run_frame(f, 0, -1);
    f = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_frame(f, 0, -1);
    f = '{16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_frame(f, 0, -1);
    // input gaps plus a back-pressure stall on beat 2
    f = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000, 16'h1400};
    run_frame(f, 2, 2);
    // max not at the end, ties for the maximum
    f = '{16'h0E00, 16'hFB00, 16'h0300, 16'h0E00, 16'hF000};
    run_frame(f, 1, -1);

    // reset in the middle of DIV aborts the frame
    f = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
    send_frame(f, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready_after", in_ready, 1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_emit", seen, 0);
    f = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000, 16'h1400};
    run_frame(f, 0, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r < 2) f[i] = 16'($urandom_range(0, 8191)) - 16'd4096;
        else       f[i] = 16'($urandom_range(0, 65535));
      end
      run_frame(f, r, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
